// File: rtl/fft_pkg.sv
// Shared FFT datapath constants, complex sample type and the round/saturate helper.
package fft_pkg;

  localparam int unsigned NBITS = 11;
  localparam int unsigned FRAC  = NBITS - 2;
  localparam int unsigned PW    = 2 * NBITS;
  localparam int unsigned ACCW  = 2 * NBITS + 1;

  localparam logic signed [ACCW-1:0]  RND_OFS = ACCW'(2 ** (FRAC - 1));
  localparam logic signed [NBITS-1:0] SAT_MAX = {1'b0, {(NBITS - 1){1'b1}}};
  localparam logic signed [NBITS-1:0] SAT_MIN = {1'b1, {(NBITS - 1){1'b0}}};

  typedef struct packed {
    logic signed [NBITS-1:0] re;
    logic signed [NBITS-1:0] im;
  } cplx_t;

  // Round half up toward +inf, rescale by FRAC, clamp to the sample range.
  function automatic logic signed [NBITS-1:0] round_sat(input logic signed [ACCW-1:0] acc);
    logic signed [ACCW-1:0] r;
    r = (acc + RND_OFS) >>> FRAC;
    if (r > ACCW'(SAT_MAX)) begin
      return SAT_MAX;
    end else if (r < ACCW'(SAT_MIN)) begin
      return SAT_MIN;
    end
    return NBITS'(r);
  endfunction

endpackage

// File: rtl/cplx_mul_rs.sv
// Two-stage complex multiplier: registered partial products, then combine/round/saturate.
module cplx_mul_rs
  import fft_pkg::*;
#(
  parameter int unsigned SW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          in_valid,
  input  cplx_t         a,
  input  cplx_t         b,
  input  logic [SW-1:0] in_side,
  output logic          out_valid,
  output cplx_t         y,
  output logic [SW-1:0] out_side
);

  logic                 p_valid_q, p_valid_d;
  logic signed [PW-1:0] rr_q, rr_d, ii_q, ii_d, ri_q, ri_d, ir_q, ir_d;
  logic [SW-1:0]        p_side_q, p_side_d;
  logic                 o_valid_q, o_valid_d;
  cplx_t                o_y_q, o_y_d;
  logic [SW-1:0]        o_side_q, o_side_d;

  // Both stages move together on en; data only loads behind a valid sample.
  always_comb begin
    p_valid_d = p_valid_q;
    rr_d      = rr_q;
    ii_d      = ii_q;
    ri_d      = ri_q;
    ir_d      = ir_q;
    p_side_d  = p_side_q;
    o_valid_d = o_valid_q;
    o_y_d     = o_y_q;
    o_side_d  = o_side_q;
    if (en) begin
      p_valid_d = in_valid;
      if (in_valid) begin
        rr_d     = PW'(a.re) * PW'(b.re);
        ii_d     = PW'(a.im) * PW'(b.im);
        ri_d     = PW'(a.re) * PW'(b.im);
        ir_d     = PW'(a.im) * PW'(b.re);
        p_side_d = in_side;
      end
      o_valid_d = p_valid_q;
      if (p_valid_q) begin
        o_y_d.re = round_sat(ACCW'(rr_q) - ACCW'(ii_q));
        o_y_d.im = round_sat(ACCW'(ri_q) + ACCW'(ir_q));
        o_side_d = p_side_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_valid_q <= 1'b0;
      rr_q      <= '0;
      ii_q      <= '0;
      ri_q      <= '0;
      ir_q      <= '0;
      p_side_q  <= '0;
      o_valid_q <= 1'b0;
      o_y_q     <= '0;
      o_side_q  <= '0;
    end else begin
      p_valid_q <= p_valid_d;
      rr_q      <= rr_d;
      ii_q      <= ii_d;
      ri_q      <= ri_d;
      ir_q      <= ir_d;
      p_side_q  <= p_side_d;
      o_valid_q <= o_valid_d;
      o_y_q     <= o_y_d;
      o_side_q  <= o_side_d;
    end
  end

  assign out_valid = o_valid_q;
  assign y         = o_y_q;
  assign out_side  = o_side_q;

endmodule

// File: rtl/twiddle_apply.sv
// Multiplies a framed complex sample stream by the twiddle selected by position in the frame.
module twiddle_apply
  import fft_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NBITS*N*2-1:0]       coeff_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [NBITS-1:0]    in_re,
  input  logic signed [NBITS-1:0]    in_im,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [NBITS-1:0]    out_re,
  output logic signed [NBITS-1:0]    out_im,
  output logic                       out_last,
  output logic [$clog2(N)-1:0]       out_idx
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned SW = IW + 1;

  logic          adv;
  logic [IW-1:0] idx_q, idx_d;
  logic          s1_valid_q, s1_valid_d;
  cplx_t         s1_a_q, s1_a_d;
  cplx_t         s1_b_q, s1_b_d;
  logic          s1_last_q, s1_last_d;
  logic [IW-1:0] s1_idx_q, s1_idx_d;
  cplx_t         prod;
  logic [SW-1:0] out_side;
  cplx_t         coeff_arr [N];

  // Entry 0 sits in the most significant slot of the packed bus.
  for (genvar k = 0; k < N; k++) begin : g_unpack
    assign coeff_arr[k] = coeff_data[2*NBITS*(N-k)-1 -: 2*NBITS];
  end

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Capture stage; in_last restarts the frame position for the next sample.
  always_comb begin
    idx_d      = idx_q;
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_last_d  = s1_last_q;
    s1_idx_d   = s1_idx_q;
    if (adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d.re = in_re;
        s1_a_d.im = in_im;
        s1_b_d    = coeff_arr[idx_q];
        s1_last_d = in_last;
        s1_idx_d  = idx_q;
        idx_d     = (in_last || idx_q == IW'(N - 1)) ? '0 : idx_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_last_q  <= 1'b0;
      s1_idx_q   <= '0;
    end else begin
      idx_q      <= idx_d;
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_last_q  <= s1_last_d;
      s1_idx_q   <= s1_idx_d;
    end
  end

  cplx_mul_rs #(
    .SW (SW)
  ) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (adv),
    .in_valid  (s1_valid_q),
    .a         (s1_a_q),
    .b         (s1_b_q),
    .in_side   ({s1_last_q, s1_idx_q}),
    .out_valid (out_valid),
    .y         (prod),
    .out_side  (out_side)
  );

  assign out_re              = prod.re;
  assign out_im              = prod.im;
  assign {out_last, out_idx} = out_side;

endmodule
